// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared widths, tag constants and result types for the CDB arbiter
package cdb_arbiter_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ROB_TAG_WIDTH = 5;

  localparam logic [ROB_TAG_WIDTH-1:0] ZERO_ROB_TAG = '0;

  typedef logic [ROB_TAG_WIDTH-1:0] rob_tag_t;
  typedef logic [DATA_WIDTH-1:0]    data_t;

  // One buffered load/store result; LSB results never carry jump information.
  typedef struct packed {
    rob_tag_t tag;
    data_t    value;
  } lsb_entry_t;

  typedef struct packed {
    rob_tag_t tag;
    data_t    value;
    logic     jump;
    data_t    target;
  } cdb_result_t;

  localparam cdb_result_t IDLE_RESULT = '{tag: ZERO_ROB_TAG, value: '0, jump: 1'b0, target: '0};

  function automatic logic tag_valid(input rob_tag_t tag);
    return tag != ZERO_ROB_TAG;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer inputs and broadcast outputs of the common data bus
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
  ();

  logic     in_misbranch;
  rob_tag_t in_alu_reorder;
  data_t    in_alu_value;
  logic     in_alu_jump;
  data_t    in_alu_target;
  rob_tag_t in_lsb_reorder;
  data_t    in_lsb_value;
  logic     out_lsb_ready;
  rob_tag_t out_update_reorder;
  data_t    out_update_value;
  logic     out_update_jump;
  data_t    out_update_target;

  modport master (
    output in_misbranch,
    output in_alu_reorder, in_alu_value, in_alu_jump, in_alu_target,
    output in_lsb_reorder, in_lsb_value,
    input  out_lsb_ready,
    input  out_update_reorder, out_update_value, out_update_jump, out_update_target
  );

  modport slave (
    input  in_misbranch,
    input  in_alu_reorder, in_alu_value, in_alu_jump, in_alu_target,
    input  in_lsb_reorder, in_lsb_value,
    output out_lsb_ready,
    output out_update_reorder, out_update_value, out_update_jump, out_update_target
  );

endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// rtl/cdb_arbiter_result_fifo.sv - ordered buffer of LSB results waiting for a free CDB slot
module result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   push,
  input  lsb_entry_t             push_data,
  input  logic                   pop,
  output lsb_entry_t             head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  lsb_entry_t    mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[head_q];

  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign push_ok = push && !flush && ((count_q != FULL_CNT) || pop_ok);
  assign pop_ok  = pop && !flush && !empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + PTR_ONE;
      if (pop_ok)  head_d = head_q + PTR_ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (en) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en && push_ok) mem_q[tail_q] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - picks one ALU or LSB result per cycle and broadcasts it on the CDB
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  cdb_arbiter_if.slave cdb
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  cdb_result_t   out_q, out_d;
  lsb_entry_t    fifo_head;
  lsb_entry_t    lsb_entry;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_push, fifo_pop, fifo_flush;
  logic          lsb_ready;
  logic          alu_valid, lsb_valid;

  assign lsb_ready = (fifo_count < DEPTH_CNT) && !cdb.in_misbranch;
  assign alu_valid = tag_valid(cdb.in_alu_reorder);
  // An LSB result offered while not ready is a protocol violation and is dropped.
  assign lsb_valid = tag_valid(cdb.in_lsb_reorder) && lsb_ready;
  assign lsb_entry = '{tag: cdb.in_lsb_reorder, value: cdb.in_lsb_value};

  result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (lsb_entry),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_comb begin
    out_d      = IDLE_RESULT;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    if (cdb.in_misbranch) begin
      fifo_flush = 1'b1;
    end else if (alu_valid) begin
      out_d.tag    = cdb.in_alu_reorder;
      out_d.value  = cdb.in_alu_value;
      out_d.jump   = cdb.in_alu_jump;
      out_d.target = cdb.in_alu_target;
      fifo_push    = lsb_valid;
    end else if (!fifo_empty) begin
      // Queued results go first so LSB order is kept; a new one joins the tail.
      out_d.tag   = fifo_head.tag;
      out_d.value = fifo_head.value;
      fifo_pop    = 1'b1;
      fifo_push   = lsb_valid;
    end else if (lsb_valid) begin
      out_d.tag   = cdb.in_lsb_reorder;
      out_d.value = cdb.in_lsb_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= IDLE_RESULT;
    end else if (rdy) begin
      out_q <= out_d;
    end
  end

  assign cdb.out_lsb_ready      = lsb_ready;
  assign cdb.out_update_reorder = out_q.tag;
  assign cdb.out_update_value   = out_q.value;
  assign cdb.out_update_jump    = out_q.jump;
  assign cdb.out_update_target  = out_q.target;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, LSB-result buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  clock, all state on posedge.
REQ-003 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-004 SHALL have port rdy  input  1  global enable; low freezes all state and outputs.
REQ-005 SHALL have port in_misbranch  input  1  pipeline flush request.
REQ-006 SHALL have port in_alu_reorder  input  ROB_TAG_WIDTH  ALU result tag; ZERO_ROB_TAG = no result.
REQ-007 SHALL have port in_alu_value  input  DATA_WIDTH  ALU result value.
REQ-008 SHALL have port in_alu_jump  input  1  branch/jump taken.
REQ-009 SHALL have port in_alu_target  input  DATA_WIDTH  branch/jump target pc.
REQ-010 SHALL have port in_lsb_reorder  input  ROB_TAG_WIDTH  load/store result tag; ZERO_ROB_TAG = none.
REQ-011 SHALL have port in_lsb_value  input  DATA_WIDTH  load data.
REQ-012 SHALL have port out_lsb_ready  output  1  high when LSB may present a result this cycle.
REQ-013 SHALL have ports out_update_reorder (ROB_TAG_WIDTH), out_update_value (DATA_WIDTH), out_update_jump (1), out_update_target (DATA_WIDTH), all outputs, registered broadcast to RS, LSB and ROB.

Function
REQ-014 SHALL broadcast at most one result per cycle, one cycle after acceptance (registered output).
REQ-015 SHALL broadcast ZERO_ROB_TAG with value, jump and target zero in any cycle with nothing to send.
REQ-016 SHALL always accept a valid ALU result (ALU has no stall); ALU priority over all LSB results.
REQ-017 SHALL, with no valid ALU result and FIFO empty, broadcast a valid LSB input directly (bypass, no enqueue).
REQ-018 SHALL, with no valid ALU result and FIFO non-empty, broadcast the FIFO head (pop); a same-cycle valid LSB input is enqueued (simultaneous push/pop, count unchanged).
REQ-019 SHALL, with a valid ALU result and valid LSB input, broadcast ALU and enqueue LSB.
REQ-020 SHALL broadcast LSB-sourced results with jump=0, target=0.
REQ-021 SHALL preserve LSB result order (FIFO); head/tail pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-022 SHALL drive out_lsb_ready combinationally = (count < FIFO_DEPTH) and not in_misbranch.
REQ-023 SHALL ignore a valid LSB input while out_lsb_ready is low (protocol violation, dropped, no state change).
REQ-024 SHALL, when in_misbranch high (rdy high), empty the FIFO, discard both inputs that cycle, and broadcast ZERO_ROB_TAG next cycle.
REQ-025 SHALL, when rdy low, hold FIFO, count and output registers; inputs ignored.

Reset
REQ-026 SHALL, on rst high at a clock edge, set count, head, tail to 0 and all out_update_* to zero, regardless of rdy or in-flight entries.
REQ-027 SHALL take rst precedence over in_misbranch and rdy; out_lsb_ready high in the cycle after reset release.

Structure
REQ-028 SHALL take DATA_WIDTH, ROB_TAG_WIDTH, ZERO_ROB_TAG from the shared defines file; no local redefinition.
REQ-029 SHALL implement the buffer as one sub-module result_fifo (tag+value, push/pop/flush, count); arbitration in cdb_arbiter.

Verification
REQ-030 Reset: rst=1 two cycles -> out_update_reorder=0, out_update_value=0, out_lsb_ready=1.
REQ-031 ALU only: alu tag 3, value 0x10, jump 1, target 0x200 -> next cycle out tag 3, value 0x10, jump 1, target 0x200; following cycle tag 0.
REQ-032 Collision: alu tag 2/0xA and lsb tag 5/0xB same cycle -> cycle+1 tag 2/0xA, cycle+2 tag 5/0xB jump 0.
REQ-033 Full: ALU valid every cycle with 4 LSB results (tags 4..7) -> out_lsb_ready=0 after 4th; ALU idle -> LSB drains tags 4,5,6,7 in order, ready high after first pop.
REQ-034 Flush: FIFO holds 3 entries, in_misbranch=1 with alu tag 1 -> next cycle tag 0, FIFO empty, later no stale tags broadcast.
REQ-035 Stall: rdy=0 for 3 cycles with output tag 6 and 2 queued -> outputs held at tag 6, queue intact, drains correctly once rdy=1.
